// File: rtl/prt_dprx_dscrm.sv
// DP RX descrambler: classifies K-codes, descrambles data with the x^16+x^5+x^4+x^3+1 LFSR,
// resyncs on SR, tracks scrambler lock and counts illegal K-codes.
module prt_dprx_dscrm #(
  parameter int unsigned P_SIM     = 0,
  parameter int unsigned P_SPL     = 2,
  parameter int unsigned P_SR_INTV = 512
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_ctl_en,
  input  logic               i_ctl_mst,
  input  logic               i_phy_vld,
  input  logic [P_SPL-1:0]   i_phy_k,
  input  logic [8*P_SPL-1:0] i_phy_dat,
  output logic               o_lnk_vld,
  output logic [4*P_SPL-1:0] o_lnk_sym,
  output logic [3*P_SPL-1:0] o_lnk_idx,
  output logic [8*P_SPL-1:0] o_lnk_dat,
  output logic               o_sta_lock,
  output logic [15:0]        o_sta_err
);

  localparam int unsigned LP_LIMIT = (P_SIM != 0) ? 4 : P_SR_INTV;
  localparam int unsigned LP_CW    = $clog2(LP_LIMIT + 1);

  typedef enum logic {StHunt, StLock} state_t;

  // Eight serial steps of the Galois-form LFSR; one byte's worth of advance.
  function automatic logic [15:0] f_step8(input logic [15:0] s);
    logic [15:0] v;
    v = s;
    for (int b = 0; b < 8; b++) begin
      v = {v[14:0], 1'b0} ^ (v[15] ? 16'h0039 : 16'h0000);
    end
    return v;
  endfunction

  state_t           r_state;
  logic [15:0]      r_lfsr;
  logic [LP_CW-1:0] r_bs_cnt;
  logic [15:0]      r_err;
  logic             r_mst;

  logic [4*P_SPL-1:0] w_sym;
  logic [3*P_SPL-1:0] w_idx;
  logic [8*P_SPL-1:0] w_dat;
  logic [15:0]        w_lfsr_nxt;
  state_t             w_state_nxt;
  logic [LP_CW-1:0]   w_cnt_nxt;
  logic [15:0]        w_err_nxt;

  always_comb begin
    logic [15:0] v_cur;
    logic [8:0]  v_code;
    logic [3:0]  v_s;
    logic [2:0]  v_raw;
    logic        v_sr;
    w_sym       = '0;
    w_idx       = '0;
    w_dat       = '0;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_bs_cnt;
    w_err_nxt   = r_err;
    v_cur       = i_ctl_en ? r_lfsr : 16'h0000;
    for (int i = 0; i < P_SPL; i++) begin
      v_code = {i_phy_k[i], i_phy_dat[8*i +: 8]};
      v_s    = 4'd0;
      v_raw  = 3'd0;
      if (i_phy_k[i] && !i_ctl_mst) begin
        case (v_code)
          9'h11C:  v_s = 4'd1;
          9'h1BC:  v_s = 4'd2;
          9'h1FB:  v_s = 4'd3;
          9'h15C:  v_s = 4'd4;
          9'h1FD:  v_s = 4'd5;
          9'h1FE:  v_s = 4'd6;
          9'h1F7:  v_s = 4'd7;
          9'h17C:  v_s = 4'd8;
          default: v_s = 4'd15;
        endcase
      end else if (i_phy_k[i]) begin
        v_s = 4'd10;
        case (v_code)
          9'h1BC:  v_s   = 4'd9;
          9'h1F7:  v_raw = 3'd0;
          9'h1FB:  v_raw = 3'd1;
          9'h11C:  v_raw = 3'd2;
          9'h15C:  v_raw = 3'd3;
          9'h17C:  v_raw = 3'd4;
          9'h1DC:  v_raw = 3'd5;
          9'h1FD:  v_raw = 3'd6;
          9'h1FE:  v_raw = 3'd7;
          default: v_s   = 4'd15;
        endcase
      end
      w_sym[4*i +: 4] = v_s;
      if (v_s == 4'd0) begin
        for (int j = 0; j < 8; j++) begin
          w_dat[8*i+j] = i_phy_dat[8*i+j] ^ v_cur[15-j];
        end
      end
      if (v_s == 4'd10) begin
        w_idx[3*i +: 3] = v_raw ^ {v_cur[13], v_cur[14], v_cur[15]};
      end
      v_sr = (v_s == 4'd1) || (v_s == 4'd9);
      // Sublane order matters: an SR later in the word rescues a BS that hit the limit.
      if (v_sr) begin
        w_state_nxt = StLock;
        w_cnt_nxt   = '0;
      end else if (v_s == 4'd2 && w_state_nxt == StLock) begin
        if (w_cnt_nxt == LP_CW'(LP_LIMIT - 1)) begin
          w_state_nxt = StHunt;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_nxt + 1'b1;
        end
      end
      if (v_s == 4'd15 && w_err_nxt != 16'hFFFF) begin
        w_err_nxt = w_err_nxt + 16'd1;
      end
      if (!i_ctl_en) begin
        v_cur = 16'h0000;
      end else if (v_sr) begin
        v_cur = 16'hFFFF;
      end else begin
        v_cur = f_step8(v_cur);
      end
    end
    w_lfsr_nxt = v_cur;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_lnk_vld <= 1'b0;
      o_lnk_sym <= '0;
      o_lnk_idx <= '0;
      o_lnk_dat <= '0;
      r_state   <= StHunt;
      r_lfsr    <= 16'hFFFF;
      r_bs_cnt  <= '0;
      r_err     <= '0;
      r_mst     <= 1'b0;
    end else begin
      r_mst     <= i_ctl_mst;
      o_lnk_vld <= i_phy_vld;
      if (i_phy_vld) begin
        o_lnk_sym <= w_sym;
        o_lnk_idx <= w_idx;
        o_lnk_dat <= w_dat;
      end
      if (!i_ctl_en || (i_ctl_mst != r_mst)) begin
        r_state  <= StHunt;
        r_lfsr   <= 16'hFFFF;
        r_bs_cnt <= '0;
        if (!i_ctl_en) begin
          r_err <= '0;
        end
      end else if (i_phy_vld) begin
        r_state  <= w_state_nxt;
        r_lfsr   <= w_lfsr_nxt;
        r_bs_cnt <= w_cnt_nxt;
        r_err    <= w_err_nxt;
      end
    end
  end

  assign o_sta_lock = (r_state == StLock);
  assign o_sta_err  = r_err;

endmodule

// File: tb/tb_prt_dprx_dscrm.sv
// Directed bench for prt_dprx_dscrm (P_SPL=2, P_SIM=1); expected values are the known
// DP scrambler byte masks from seed FFFFh: FF 17 C0 14 B2 E7.
module tb_prt_dprx_dscrm;

  logic        clk = 1'b0;
  logic        rst_n, en, mst, vld;
  logic [1:0]  k;
  logic [15:0] dat;
  logic        o_vld, o_lock;
  logic [7:0]  o_sym;
  logic [5:0]  o_idx;
  logic [15:0] o_dat, o_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  prt_dprx_dscrm #(
    .P_SIM     (1),
    .P_SPL     (2),
    .P_SR_INTV (512)
  ) u_dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_ctl_en   (en),
    .i_ctl_mst  (mst),
    .i_phy_vld  (vld),
    .i_phy_k    (k),
    .i_phy_dat  (dat),
    .o_lnk_vld  (o_vld),
    .o_lnk_sym  (o_sym),
    .o_lnk_idx  (o_idx),
    .o_lnk_dat  (o_dat),
    .o_sta_lock (o_lock),
    .o_sta_err  (o_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one word {c1, c0} (9-bit {k,byte} codes) and sample 1 ns after the capturing edge.
  task automatic put(input logic v, input logic [8:0] c0, input logic [8:0] c1);
    @(negedge clk);
    vld = v;
    k   = {c1[8], c0[8]};
    dat = {c1[7:0], c0[7:0]};
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; mst = 1'b0; vld = 1'b0; k = '0; dat = '0;
    put(0, 9'h000, 9'h000);
    put(1, 9'h11C, 9'h0FF);
    chk("rst_vld", o_vld, 0);
    chk("rst_sym", o_sym, 0);
    chk("rst_dat", o_dat, 0);
    chk("rst_lock", o_lock, 0);
    chk("rst_err", o_err, 0);
    rst_n = 1'b1;

    put(1, 9'h11C, 9'h0FF);
    chk("sr_vld", o_vld, 1);
    chk("sr_sym", o_sym, 8'h01);
    chk("sr_dat", o_dat, 16'h0000);
    chk("sr_lock", o_lock, 1);
    put(1, 9'h017, 9'h0C0);
    chk("dat2", o_dat, 16'h0000);
    chk("dat2_sym", o_sym, 8'h00);
    put(1, 9'h014, 9'h0AA);
    chk("dat3", o_dat, 16'h1800);
    put(1, 9'h0AA, 9'h11C);
    chk("xw_sym", o_sym, 8'h10);
    chk("xw_dat", o_dat, 16'h004D);
    put(0, 9'h055, 9'h066);
    chk("gap_vld", o_vld, 0);
    chk("gap_hold", o_dat, 16'h004D);
    put(1, 9'h0FF, 9'h017);
    chk("xw_reset", o_dat, 16'h0000);
    chk("xw_lock", o_lock, 1);

    for (int i = 0; i < 3; i++) put(1, 9'h1BC, 9'h000);
    chk("bs3_lock", o_lock, 1);
    chk("bs_sym", o_sym, 8'h02);
    put(1, 9'h1BC, 9'h000);
    chk("bs4_unlock", o_lock, 0);
    put(1, 9'h11C, 9'h0FF);
    chk("relock", o_lock, 1);
    chk("relock_dat", o_dat, 16'h0000);
    for (int i = 0; i < 3; i++) put(1, 9'h1BC, 9'h000);
    put(1, 9'h1BC, 9'h11C);
    chk("bs_sr_word", o_lock, 1);
    for (int i = 0; i < 3; i++) put(1, 9'h1BC, 9'h000);
    chk("cnt_cleared", o_lock, 1);
    put(1, 9'h1BC, 9'h000);
    chk("bs4_unlock2", o_lock, 0);

    put(1, 9'h13C, 9'h13C);
    chk("err_sym", o_sym, 8'hFF);
    chk("err_cnt2", o_err, 2);
    put(1, 9'h1BC, 9'h13C);
    chk("err_sym2", o_sym, 8'hF2);
    chk("err_cnt3", o_err, 3);
    chk("hunt_bs", o_lock, 0);

    en = 1'b0;
    put(1, 9'h0A5, 9'h05A);
    chk("byp_dat", o_dat, 16'h5AA5);
    chk("byp_err", o_err, 0);
    chk("byp_lock", o_lock, 0);
    en = 1'b1;
    for (int i = 0; i < 32767; i++) put(1, 9'h13C, 9'h13C);
    chk("err_fffe", o_err, 16'hFFFE);
    put(1, 9'h13C, 9'h13C);
    chk("err_sat", o_err, 16'hFFFF);
    put(1, 9'h13C, 9'h13C);
    chk("err_hold", o_err, 16'hFFFF);

    en = 1'b0; mst = 1'b1;
    put(0, 9'h000, 9'h000);
    en = 1'b1;
    put(1, 9'h1BC, 9'h11C);
    chk("mst_sym", o_sym, 8'hA9);
    chk("mst_idx", o_idx, 6'h28);
    chk("mst_lock", o_lock, 1);
    put(1, 9'h017, 9'h0C0);
    chk("mst_dat", o_dat, 16'h0000);

    rst_n = 1'b0;
    put(1, 9'h0AA, 9'h0BB);
    chk("mrst_vld", o_vld, 0);
    chk("mrst_sym", o_sym, 0);
    chk("mrst_dat", o_dat, 0);
    chk("mrst_idx", o_idx, 0);
    chk("mrst_lock", o_lock, 0);
    rst_n = 1'b1;
    put(0, 9'h000, 9'h000);
    chk("post_rst_vld", o_vld, 0);
    put(1, 9'h1BC, 9'h0FF);
    chk("post_rst_sym", o_sym, 8'h09);
    chk("post_rst_dat", o_dat, 16'h0000);
    chk("post_rst_lock", o_lock, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
